// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Shares one registered W-bit adder among NREQ requesters. A round-robin
//   scheduler grants one requester at a time (IDLE), the add is performed in
//   a single cycle (CALC), and the result is held on the result port until
//   the consumer accepts it (RESP). Only one operation is in flight.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   req_valid  per-requester operand-pair valid
//   req_ready  per-requester accept (one-hot or zero, only in IDLE)
//   req_a      operand A, requester i at [i*W +: W]
//   req_b      operand B, same packing
//   res_valid  result available
//   res_ready  consumer accepts result
//   res_sum    (a+b) mod 2^W
//   res_carry  carry out of the W-bit add
//   res_id     index of the requester owning the result
//   busy       high in every state except IDLE
module adder_share_arbiter #(
  parameter int W    = 8,
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [W-1:0]        res_sum,
  output logic                res_carry,
  output logic [IDW-1:0]      res_id,
  output logic                busy
);

  localparam logic [IDW:0]   NREQ_L = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [W-1:0]   a_q, b_q;
  logic [IDW-1:0] g_q;
  logic           res_valid_q, res_valid_d;
  logic [W-1:0]   res_sum_q, res_sum_d;
  logic           res_carry_q, res_carry_d;
  logic [IDW-1:0] res_id_q, res_id_d;

  logic [2*NREQ-1:0] dbl_valid;
  logic              gnt_found;
  logic [IDW-1:0]    gnt_idx;
  logic [W-1:0]      a_sel, b_sel;
  logic              take;
  logic [W:0]        add_res;

  function automatic logic [W:0] add_wc(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Rotate the valid vector so bit k of the shifted copy is requester
  // (ptr+k) mod NREQ; the first set bit is the grant. Works for any NREQ.
  always_comb begin
    logic [IDW:0] idx;
    dbl_valid = {req_valid, req_valid} >> ptr_q;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= NREQ_L) idx = idx - NREQ_L;
      if (!gnt_found && dbl_valid[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
      end
    end
  end

  // The rst gate keeps req_ready low in the reset cycle even if the state
  // register already reads IDLE.
  assign take = (state_q == IDLE) && gnt_found && !rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = take && (gnt_idx == IDW'(i));
    end
  end

  assign add_res = add_wc(a_q, b_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_carry_d = res_carry_q;
    res_id_d    = res_id_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          ptr_d   = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        res_carry_d = add_res[W];
        res_sum_d   = add_res[W-1:0];
        res_id_d    = g_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_carry_q <= res_carry_d;
      res_id_q    <= res_id_d;
    end
  end

  // Operand capture at grant
  always_ff @(posedge clk) begin
    if (take) begin
      a_q <= a_sel;
      b_q <= b_sel;
      g_q <= gnt_idx;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_carry = res_carry_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic        res_valid, res_ready;
  logic [7:0]  res_sum;
  logic        res_carry;
  logic [1:0]  res_id;
  logic        busy;

  logic [2:0]  v3, rdy3;
  logic [23:0] a3p, b3p;
  logic        rv3, rr3;
  logic [7:0]  sum3;
  logic        c3;
  logic [1:0]  id3;
  logic        busy3;

  int tests = 0;
  int fails = 0;

  logic [7:0]  a_m [4];
  logic [7:0]  b_m [4];
  logic [10:0] sb [$];   // {id[1:0], carry, sum[7:0]}

  always #5 clk = ~clk;

  adder_share_arbiter #(.W(8), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_carry(res_carry), .res_id(res_id), .busy(busy)
  );

  adder_share_arbiter #(.W(8), .NREQ(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3),
    .req_a(a3p), .req_b(b3p), .res_valid(rv3), .res_ready(rr3),
    .res_sum(sum3), .res_carry(c3), .res_id(id3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = a_m[i];
      req_b[i*8 +: 8] = b_m[i];
    end
  endtask

  // Drives one full IDLE->CALC->RESP sequence on the 4-requester DUT.
  // Called with the DUT in IDLE; returns in the cycle after the result
  // handshake (DUT back in IDLE).
  task automatic issue(input logic [3:0] vmask, input int exp_g, input int stall, input string tag);
    logic [8:0]  e;
    logic [10:0] r;
    logic [3:0]  oh;
    req_valid = vmask;
    res_ready = (stall == 0);
    oh = 4'b0001 << exp_g;
    @(negedge clk);
    chk({tag, ".grant"}, 32'(req_ready), 32'(oh));
    e = {1'b0, a_m[exp_g]} + {1'b0, b_m[exp_g]};
    sb.push_back({2'(exp_g), e});
    next_cycle();
    @(negedge clk);
    chk({tag, ".calc_ready"}, 32'(req_ready), 32'h0);
    chk({tag, ".calc_busy"}, 32'(busy), 32'h1);
    chk({tag, ".calc_valid"}, 32'(res_valid), 32'h0);
    next_cycle();
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, ".stall_valid"}, 32'(res_valid), 32'h1);
      chk({tag, ".stall_ready"}, 32'(req_ready), 32'h0);
      chk({tag, ".stall_sum"}, 32'(res_sum), 32'(sb[0][7:0]));
      chk({tag, ".stall_id"}, 32'(res_id), 32'(sb[0][10:9]));
      next_cycle();
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".resp_valid"}, 32'(res_valid), 32'h1);
    chk({tag, ".resp_ready"}, 32'(req_ready), 32'h0);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'h1, 32'h0);
    end else begin
      r = sb.pop_front();
      chk({tag, ".sum"}, 32'(res_sum), 32'(r[7:0]));
      chk({tag, ".carry"}, 32'(res_carry), 32'(r[8]));
      chk({tag, ".id"}, 32'(res_id), 32'(r[10:9]));
    end
    next_cycle();
  endtask

  // Same sequence on the 3-requester DUT; operands of requester i are
  // a = 8'h10*(i+1), b = i+1.
  task automatic op3(input logic [2:0] vmask, input int exp_g, input string tag);
    logic [7:0] es;
    v3 = vmask;
    @(negedge clk);
    chk({tag, ".grant"}, 32'(rdy3), 32'(3'b001 << exp_g));
    es = 8'((exp_g + 1) * 16 + (exp_g + 1));
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk({tag, ".valid"}, 32'(rv3), 32'h1);
    chk({tag, ".id"}, 32'(id3), 32'(exp_g));
    chk({tag, ".sum"}, 32'(sum3), 32'(es));
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 4'b0001;
    res_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    v3 = 3'b000;
    rr3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a3p[i*8 +: 8] = 8'((i + 1) * 16);
      b3p[i*8 +: 8] = 8'(i + 1);
    end
    a_m[0] = 8'h12; b_m[0] = 8'h34;
    a_m[1] = 8'h80; b_m[1] = 8'h80;
    a_m[2] = 8'hFF; b_m[2] = 8'h01;
    a_m[3] = 8'h7F; b_m[3] = 8'h01;
    apply_ops();

    // Reset for two cycles, with a request pending
    next_cycle();
    @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'h0);
    chk("rst.res_valid", 32'(res_valid), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.res_sum", 32'(res_sum), 32'h0);
    chk("rst.res_id", 32'(res_id), 32'h0);
    next_cycle();
    rst = 1'b0;

    // Single op on requester 0
    issue(4'b0001, 0, 0, "single");
    req_valid = 4'b0000;
    @(negedge clk);
    chk("single.busy_c3", 32'(busy), 32'h0);
    chk("single.idle_ready", 32'(req_ready), 32'h0);
    chk("single.hold_sum", 32'(res_sum), 32'h46);
    next_cycle();

    // Carry out on requester 2
    issue(4'b0100, 2, 0, "carry");

    // Round robin from a fresh pointer
    req_valid = 4'b0000;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    issue(4'b1111, 0, 0, "rr0");
    issue(4'b1111, 1, 0, "rr1");
    issue(4'b1111, 2, 0, "rr2");
    issue(4'b1111, 3, 0, "rr3");
    issue(4'b1111, 0, 0, "rr4");

    // Backpressure in RESP, then the next grant right after release
    issue(4'b1111, 1, 5, "bp");
    issue(4'b1111, 2, 0, "bp_next");

    // Reset during CALC: pointer is 3 here, so requester 1 wins first
    req_valid = 4'b0010;
    @(negedge clk);
    chk("rmid.grant", 32'(req_ready), 32'h2);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rmid.calc_busy", 32'(busy), 32'h1);
    next_cycle();
    rst = 1'b0;
    req_valid = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rmid.res_valid", 32'(res_valid), 32'h0);
      chk("rmid.busy", 32'(busy), 32'h0);
      next_cycle();
    end
    @(negedge clk);
    chk("rmid.res_sum", 32'(res_sum), 32'h0);
    chk("rmid.res_carry", 32'(res_carry), 32'h0);
    chk("rmid.res_id", 32'(res_id), 32'h0);
    next_cycle();
    issue(4'b1111, 0, 0, "rmid_next");
    req_valid = 4'b0000;

    // Skip and wrap with three requesters
    op3(3'b010, 1, "n3a");
    op3(3'b001, 0, "n3b");
    op3(3'b110, 1, "n3c");
    op3(3'b011, 0, "n3d");
    v3 = 3'b000;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
